// File: rtl/maxpool1d_stage.sv
// Streaming 1D max-pool over a POOL_SIZE window stepped by STRIDE, with sequence framing.
// Latency: pool_valid/pool_out/pool_last/seq_done are registered, one cycle after the in_valid sample.
// Backpressure: none; every in_valid sample is accepted (unless clear is asserted in that cycle).
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   clear               synchronous flush back to IDLE; drops any same-cycle sample
//   in_data/in_valid    signed sample stream, arbitrary gaps allowed
//   in_last             marks the in_valid sample as the last of a sequence
//   pool_out/pool_valid signed window maximum and its one-cycle strobe (pool_out holds between strobes)
//   pool_last           final output of a sequence (only with pool_valid from an in_last sample)
//   seq_done            one-cycle pulse after every accepted in_last
//   out_count           outputs emitted in the current sequence, saturating at 255
module maxpool1d_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_SIZE  = 2,
  parameter int STRIDE     = 2,
  parameter int PARTIAL_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] pool_out,
  output logic                  pool_valid,
  output logic                  pool_last,
  output logic                  seq_done,
  output logic [7:0]            out_count
);

  // Sample counter is 4 bits wider than needed to hold POOL_SIZE and saturates.
  localparam int NW = $clog2(POOL_SIZE + 1) + 4;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [NW-1:0] N_MAX  = '1;
  localparam logic [NW-1:0] N_POOL = NW'(POOL_SIZE);
  localparam logic [SW-1:0] S_LAST = SW'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                        state_q, state_d;
  logic [NW-1:0]                 n_q, n_d;
  logic [SW-1:0]                 scnt_q, scnt_d;
  logic signed [DATA_WIDTH-1:0]  win_q [POOL_SIZE];
  logic signed [DATA_WIDTH-1:0]  win_d [POOL_SIZE];
  logic [POOL_SIZE-1:0]          mask_q, mask_d;
  logic [DATA_WIDTH-1:0]         pool_out_q, pool_out_d;
  logic                          pool_valid_q, pool_valid_d;
  logic                          pool_last_q, pool_last_d;
  logic                          seq_done_q, seq_done_d;
  logic [7:0]                    out_count_q, out_count_d;
  logic                          new_seq_q, new_seq_d;

  // Window as it will look after accepting the current sample.
  logic signed [DATA_WIDTH-1:0]  win_nx [POOL_SIZE];
  logic [POOL_SIZE-1:0]          mask_nx;
  logic [NW-1:0]                 n_inc;
  logic                          full_emit;
  logic                          part_emit;
  logic signed [DATA_WIDTH-1:0]  best;

  always_comb begin
    win_nx[0] = $signed(in_data);
    for (int i = 1; i < POOL_SIZE; i++) begin
      win_nx[i] = win_q[i-1];
    end
    mask_nx = (mask_q << 1) | {{(POOL_SIZE-1){1'b0}}, 1'b1};
    n_inc   = (n_q == N_MAX) ? n_q : n_q + NW'(1);

    // Stride counter is zero exactly on samples where (n - POOL_SIZE) mod STRIDE == 0.
    full_emit = (n_inc >= N_POOL) && (scnt_q == '0);
    part_emit = in_last && !full_emit && (PARTIAL_EN != 0);

    // Slot 0 (the new sample) is always valid; older slots only count when masked in,
    // so a short trailing window never compares against stale or zero entries.
    best = win_nx[0];
    for (int i = 1; i < POOL_SIZE; i++) begin
      if (mask_nx[i] && (win_nx[i] > best)) best = win_nx[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    scnt_d       = scnt_q;
    win_d        = win_q;
    mask_d       = mask_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    pool_last_d  = 1'b0;
    seq_done_d   = 1'b0;
    out_count_d  = out_count_q;
    new_seq_d    = new_seq_q;

    if (clear) begin
      state_d     = IDLE;
      n_d         = '0;
      scnt_d      = '0;
      mask_d      = '0;
      out_count_d = '0;
      new_seq_d   = 1'b0;
    end else if (in_valid) begin
      win_d  = win_nx;
      mask_d = mask_nx;
      n_d    = n_inc;
      if (n_inc >= N_POOL) begin
        scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + SW'(1);
      end

      unique case (state_q)
        IDLE:    state_d = (n_inc >= N_POOL) ? RUN : FILL;
        FILL:    state_d = (n_inc >= N_POOL) ? RUN : FILL;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase

      if (full_emit || part_emit) begin
        pool_valid_d = 1'b1;
        pool_out_d   = best;
        pool_last_d  = in_last;
        // First output after a completed sequence restarts the count.
        if (new_seq_q) out_count_d = 8'd1;
        else           out_count_d = (out_count_q == 8'hFF) ? 8'hFF : out_count_q + 8'd1;
        new_seq_d    = 1'b0;
      end

      if (in_last) begin
        state_d    = IDLE;
        n_d        = '0;
        scnt_d     = '0;
        mask_d     = '0;
        seq_done_d = 1'b1;
        new_seq_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      scnt_q       <= '0;
      for (int i = 0; i < POOL_SIZE; i++) win_q[i] <= '0;
      mask_q       <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      pool_last_q  <= 1'b0;
      seq_done_q   <= 1'b0;
      out_count_q  <= '0;
      new_seq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      scnt_q       <= scnt_d;
      win_q        <= win_d;
      mask_q       <= mask_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      pool_last_q  <= pool_last_d;
      seq_done_q   <= seq_done_d;
      out_count_q  <= out_count_d;
      new_seq_q    <= new_seq_d;
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign pool_last  = pool_last_q;
  assign seq_done   = seq_done_q;
  assign out_count  = out_count_q;

endmodule
